// File: rtl/cdb_arbiter_pkg.sv
// Shared result-bus types for the execute/complete boundary: the FU result
// packet, the CDB broadcast and the default number of CDB lanes.
package cdb_arbiter_pkg;

   localparam int PRF_SIZE  = 64;
   localparam int PR_W      = $clog2(PRF_SIZE);
   localparam int CDB_WIDTH = 2;

   typedef struct packed {
      logic [PR_W-1:0] pr;
      logic [31:0]     result;
      logic            halt;
      logic            w;
      logic            r;
   } EX_COMPLETE;

   typedef struct packed {
      logic [PR_W-1:0] pr;
      logic            valid;
   } CDB;

endpackage

// File: rtl/rr_select.sv
// Rotating-priority picker: starting at `start`, returns the first M set bits of
// `req` as one-hot selections, packed densely into outputs 0..M-1.
module rr_select #(
   parameter  int N  = 6,
   parameter  int M  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]        req,
   input  logic [PW-1:0]       start,
   output logic [M-1:0][N-1:0] sel,
   output logic [M-1:0]        sel_valid
);

   localparam logic [PW-1:0] LAST = PW'(N - 1);

   int            cnt;
   logic [PW-1:0] idx;

   always_comb begin
      sel       = '0;
      sel_valid = '0;
      cnt       = 0;
      idx       = start;
      for (int off = 0; off < N; off++) begin
         for (int k = 0; k < M; k++) begin
            if (req[idx] && cnt == k) begin
               sel[k][idx]  = 1'b1;
               sel_valid[k] = 1'b1;
            end
         end
         if (req[idx] && cnt < M) cnt = cnt + 1;
         // Explicit wrap so non-power-of-two N never visits a phantom index.
         idx = (idx == LAST) ? '0 : idx + PW'(1);
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Holds one finished result per FU and grants up to WIDTH of them per cycle onto
// the CDB lanes in rotating-priority order, back-pressuring FUs still waiting.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU = 6,
   parameter int WIDTH  = CDB_WIDTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rollback_en,
   input  logic [NUM_FU-1:0] fu_valid,
   input  EX_COMPLETE        fu_packet [NUM_FU],
   output logic [NUM_FU-1:0] fu_ready,
   output EX_COMPLETE        ex_complete_packet [WIDTH],
   output logic [WIDTH-1:0]  execution_complete
);

   localparam int              PTR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam logic [PTR_W-1:0] LAST_FU = PTR_W'(NUM_FU - 1);

   logic [NUM_FU-1:0]            slot_valid;
   EX_COMPLETE                   slot_pkt [NUM_FU];
   logic [PTR_W-1:0]             rr_ptr;

   logic [WIDTH-1:0][NUM_FU-1:0] sel;
   logic [WIDTH-1:0]             sel_valid;
   logic [NUM_FU-1:0]            grant;
   logic [PTR_W-1:0]             last_idx;
   logic [PTR_W-1:0]             next_ptr;
   logic                         any_grant;
   logic                         squash;

   assign squash = reset || rollback_en;

   rr_select #(.N(NUM_FU), .M(WIDTH)) u_rr_select (
      .req       (slot_valid),
      .start     (rr_ptr),
      .sel       (sel),
      .sel_valid (sel_valid)
   );

   // The highest filled lane holds the last FU granted in scan order.
   always_comb begin
      grant    = '0;
      last_idx = '0;
      for (int k = 0; k < WIDTH; k++) begin
         grant = grant | sel[k];
         for (int i = 0; i < NUM_FU; i++) begin
            if (sel[k][i]) last_idx = PTR_W'(i);
         end
      end
      any_grant = |grant;
      next_ptr  = (last_idx == LAST_FU) ? '0 : last_idx + PTR_W'(1);
   end

   assign fu_ready = squash ? '0 : (~slot_valid | grant);

   always_comb begin
      for (int k = 0; k < WIDTH; k++) begin
         execution_complete[k] = sel_valid[k] && !squash;
         ex_complete_packet[k] = '0;
         for (int i = 0; i < NUM_FU; i++) begin
            if (sel[k][i] && !squash) ex_complete_packet[k] = slot_pkt[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         slot_valid <= '0;
         rr_ptr     <= '0;
         for (int i = 0; i < NUM_FU; i++) slot_pkt[i] <= '0;
      end else if (rollback_en) begin
         slot_valid <= '0;
         rr_ptr     <= '0;
      end else begin
         // A refill wins over the drain so a granted slot can be reloaded in one cycle.
         for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) begin
               slot_pkt[i]   <= fu_packet[i];
               slot_valid[i] <= 1'b1;
            end else if (grant[i]) begin
               slot_valid[i] <= 1'b0;
            end
         end
         if (any_grant) rr_ptr <= next_ptr;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized bench for cdb_arbiter (4 FUs, 2 lanes) against a
// behavioural model of the slots and rotating priority.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int NF = 4;
   localparam int W  = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          rollback_en;
   logic [NF-1:0] fu_valid;
   EX_COMPLETE    fu_packet [NF];
   logic [NF-1:0] fu_ready;
   EX_COMPLETE    ex_complete_packet [W];
   logic [W-1:0]  execution_complete;

   int checks   = 0;
   int failures = 0;

   // Model state: what each FU's holding slot contains and whose turn is first.
   logic       m_valid [NF];
   EX_COMPLETE m_pkt   [NF];
   int         m_ptr;

   always #5 clock = ~clock;

   cdb_arbiter #(.NUM_FU(NF), .WIDTH(W)) dut (
      .clock              (clock),
      .reset              (reset),
      .rollback_en        (rollback_en),
      .fu_valid           (fu_valid),
      .fu_packet          (fu_packet),
      .fu_ready           (fu_ready),
      .ex_complete_packet (ex_complete_packet),
      .execution_complete (execution_complete)
   );

   function automatic EX_COMPLETE mk(input int pr);
      EX_COMPLETE p;
      p.pr     = PR_W'(pr);
      p.result = $urandom;
      p.halt   = 1'($urandom_range(0, 1));
      p.w      = 1'($urandom_range(0, 1));
      p.r      = 1'($urandom_range(0, 1));
      return p;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: compare outputs mid-cycle against the model, then advance the model at the edge.
   task automatic cycle();
      EX_COMPLETE    e_lane [W];
      logic [W-1:0]  e_ec;
      logic [NF-1:0] e_ready;
      logic [NF-1:0] g;
      int            found;
      int            last;
      int            i;
      @(negedge clock);
      e_ec  = '0;
      g     = '0;
      found = 0;
      last  = -1;
      for (int k = 0; k < W; k++) e_lane[k] = '0;
      if (!reset && !rollback_en) begin
         for (int off = 0; off < NF; off++) begin
            i = (m_ptr + off) % NF;
            if (m_valid[i] && found < W) begin
               e_lane[found] = m_pkt[i];
               e_ec[found]   = 1'b1;
               g[i]          = 1'b1;
               last          = i;
               found++;
            end
         end
      end
      for (int f = 0; f < NF; f++)
         e_ready[f] = !reset && !rollback_en && (!m_valid[f] || g[f]);

      check("execution_complete", 64'(execution_complete), 64'(e_ec));
      check("fu_ready", 64'(fu_ready), 64'(e_ready));
      for (int k = 0; k < W; k++)
         check($sformatf("lane%0d_packet", k), 64'(ex_complete_packet[k]), 64'(e_lane[k]));
      check("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));

      @(posedge clock);
      if (reset) begin
         for (int f = 0; f < NF; f++) begin
            m_valid[f] = 1'b0;
            m_pkt[f]   = '0;
         end
         m_ptr = 0;
      end else if (rollback_en) begin
         for (int f = 0; f < NF; f++) m_valid[f] = 1'b0;
         m_ptr = 0;
      end else begin
         for (int f = 0; f < NF; f++) begin
            if (fu_valid[f] && e_ready[f]) begin
               m_valid[f] = 1'b1;
               m_pkt[f]   = fu_packet[f];
            end else if (g[f]) begin
               m_valid[f] = 1'b0;
            end
         end
         if (last >= 0) m_ptr = (last + 1) % NF;
      end
      #1;
   endtask

   initial begin
      for (int f = 0; f < NF; f++) begin
         m_valid[f]   = 1'b0;
         m_pkt[f]     = '0;
         fu_packet[f] = mk(f + 10);
      end
      m_ptr       = 0;
      reset       = 1'b1;
      rollback_en = 1'b0;
      fu_valid    = 4'b1111;

      // Reset held two cycles with all FUs presenting: nothing captured.
      cycle();
      cycle();
      reset    = 1'b0;
      fu_valid = 4'b0000;
      cycle();

      // Single FU2 result, then pointer moves past it to 3.
      fu_valid     = 4'b0100;
      fu_packet[2] = mk(7);
      cycle();
      fu_valid = 4'b0000;
      cycle();
      check("single_pr7_ec", 64'(execution_complete), 64'(2'b00));
      cycle();

      // Wrap-around from pointer 3: FU3 then FU0.
      fu_valid     = 4'b1001;
      fu_packet[3] = mk(33);
      fu_packet[0] = mk(44);
      cycle();
      fu_valid = 4'b0000;
      cycle();
      cycle();

      // Empty rollback returns the pointer to 0.
      rollback_en = 1'b1;
      cycle();
      rollback_en = 1'b0;

      // Oversubscription: four requests, two lanes.
      fu_valid = 4'b1111;
      for (int f = 0; f < NF; f++) fu_packet[f] = mk(20 + f);
      cycle();
      fu_valid = 4'b0000;
      repeat (3) cycle();

      // Back-to-back from FU1 with no bubble.
      fu_valid = 4'b0010;
      for (int pr = 1; pr <= 3; pr++) begin
         fu_packet[1] = mk(pr);
         cycle();
      end
      fu_valid = 4'b0000;
      repeat (2) cycle();

      // Rollback with three slots occupied.
      fu_valid = 4'b0111;
      for (int f = 0; f < NF; f++) fu_packet[f] = mk(50 + f);
      cycle();
      fu_valid    = 4'b0000;
      rollback_en = 1'b1;
      cycle();
      rollback_en = 1'b0;
      repeat (2) cycle();

      // Randomized traffic with occasional rollback and reset.
      repeat (400) begin
         reset       = ($urandom_range(0, 63) == 0);
         rollback_en = ($urandom_range(0, 15) == 0);
         fu_valid    = NF'($urandom);
         for (int f = 0; f < NF; f++) fu_packet[f] = mk($urandom_range(0, PRF_SIZE - 1));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
